// File: rtl/traffic_sensor_cond_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared constants for the traffic-sensor conditioning slice: default
// parameter values for the synchronizer depth, debounce length and tick
// divider, plus the bit index used for each street in per-street vectors.
// ---------------------------------------------------------------------------
package traffic_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEB_CYCLES_DEF  = 4;
    localparam int DIV_RATIO_DEF   = 8;

    localparam int STREET_A = 0;
    localparam int STREET_B = 1;

endpackage

// File: rtl/traffic_sensor_cond_if.sv
// ---------------------------------------------------------------------------
// traffic_sensor_cond_if
// Bundles the signals between the raw sensor / controller side and the
// conditioning stage.
//   SA_RAW, SB_RAW   raw asynchronous sensor contacts
//   GA_STAT, GB_STAT green indications returned by the controller
//   SA, SB           conditioned demand to the controller
//   TICK             single-cycle state-advance enable
// Modports:
//   master : the environment (drives raw sensors and green status)
//   slave  : the conditioning stage (drives SA, SB, TICK)
// ---------------------------------------------------------------------------
interface traffic_sensor_cond_if;

    logic SA_RAW;
    logic SB_RAW;
    logic GA_STAT;
    logic GB_STAT;
    logic SA;
    logic SB;
    logic TICK;

    modport master (
        output SA_RAW, SB_RAW, GA_STAT, GB_STAT,
        input  SA, SB, TICK
    );

    modport slave (
        input  SA_RAW, SB_RAW, GA_STAT, GB_STAT,
        output SA, SB, TICK
    );

endinterface

// File: rtl/traffic_sensor_cond_sensor_debounce.sv
// ---------------------------------------------------------------------------
// sensor_debounce
// One street's input path: a SYNC_STAGES-deep synchronizer followed by a
// debounce counter. The debounced level only changes after the synchronized
// value has disagreed with it for DEB_CYCLES consecutive cycles.
// Ports:
//   CLK  system clock
//   RST  asynchronous active-high reset
//   raw  raw asynchronous sensor contact
//   deb  debounced, synchronous level
// ---------------------------------------------------------------------------
module sensor_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic deb
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_val;
    logic [CNT_W-1:0]       cnt;

    assign sync_val = sync_reg[SYNC_STAGES-1];

    // Shift register synchronizer; the oldest stage feeds the debouncer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
        end
    end

    // Any agreement with the current level restarts the stability count,
    // so glitches shorter than DEB_CYCLES never reach deb.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (sync_val == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
            deb <= sync_val;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_sensor_cond.sv
// ---------------------------------------------------------------------------
// traffic_sensor_cond
// Input conditioning ahead of the two-street traffic-light controller.
// Synchronizes and debounces both street sensors, optionally latches each
// arrival until that street turns green, and generates a free-running
// one-cycle TICK every DIV_RATIO clocks.
// Ports:
//   CLK   system clock
//   RST   asynchronous active-high reset
//   bus   traffic_sensor_cond_if.slave (SA_RAW, SB_RAW, GA_STAT, GB_STAT in;
//         SA, SB, TICK out)
// Configuration macro:
//   SENSOR_LATCH_EN  when defined, builds per-street request latches so a
//                    car that leaves before its green still holds demand.
//                    When undefined, SA/SB are the debounced levels and the
//                    green status inputs are ignored.
// ---------------------------------------------------------------------------
module traffic_sensor_cond
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int DIV_RATIO   = DIV_RATIO_DEF,
    parameter int CNT_W       = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    traffic_sensor_cond_if.slave bus
);

    logic [1:0]       raw;
    logic [1:0]       deb;
    logic [CNT_W-1:0] div_cnt;
    logic             tick;

    assign raw[STREET_A] = bus.SA_RAW;
    assign raw[STREET_B] = bus.SB_RAW;

    sensor_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES),
        .CNT_W       (CNT_W)
    ) u_deb_a (
        .CLK (CLK),
        .RST (RST),
        .raw (raw[STREET_A]),
        .deb (deb[STREET_A])
    );

    sensor_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES),
        .CNT_W       (CNT_W)
    ) u_deb_b (
        .CLK (CLK),
        .RST (RST),
        .raw (raw[STREET_B]),
        .deb (deb[STREET_B])
    );

`ifdef SENSOR_LATCH_EN
    logic [1:0] deb_prev;
    logic [1:0] req;
    logic [1:0] stat;
    logic [1:0] rise;

    assign stat[STREET_A] = bus.GA_STAT;
    assign stat[STREET_B] = bus.GB_STAT;
    assign rise           = deb & ~deb_prev;

    // Green status clears the latch and takes priority over a new arrival,
    // because that arriving car is served by the green already showing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            deb_prev <= '0;
            req      <= '0;
        end else begin
            deb_prev <= deb;
            req      <= ~stat & (req | rise);
        end
    end

    assign bus.SA = deb[STREET_A] | req[STREET_A];
    assign bus.SB = deb[STREET_B] | req[STREET_B];
`else
    logic unused_stat;

    assign unused_stat = bus.GA_STAT ^ bus.GB_STAT;

    assign bus.SA = deb[STREET_A];
    assign bus.SB = deb[STREET_B];
`endif

    // Divider wraps at DIV_RATIO-1; TICK is registered so it appears in the
    // cycle after the terminal count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= (div_cnt == CNT_W'(DIV_RATIO - 1));
            if (div_cnt == CNT_W'(DIV_RATIO - 1)) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    assign bus.TICK = tick;

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// ---------------------------------------------------------------------------
// tb_traffic_sensor_cond
// Self-checking bench for traffic_sensor_cond. A behavioural model tracks the
// expected SA, SB and TICK each cycle; directed steps cover reset, clean
// edges, bounce, simultaneous arrivals and (with SENSOR_LATCH_EN) the request
// latch, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_traffic_sensor_cond;
    import traffic_pkg::*;

    localparam int SYNC = SYNC_STAGES_DEF;
    localparam int DEB  = DEB_CYCLES_DEF;
    localparam int DIV  = DIV_RATIO_DEF;
    localparam int LAT  = SYNC + DEB;
`ifdef SENSOR_LATCH_EN
    localparam bit LATCH_ON = 1'b1;
`else
    localparam bit LATCH_ON = 1'b0;
`endif

    logic CLK;
    logic RST;

    traffic_sensor_cond_if bus ();

    traffic_sensor_cond dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: delay lines model the synchronizer lag, the
    // debounced level flips after DEB consecutive disagreeing samples.
    bit dly_a[$];
    bit dly_b[$];
    bit m_deb  [2];
    int m_run  [2];
    bit m_req  [2];
    bit m_rose [2];
    int cyc_n;

    task automatic resetModel();
        dly_a.delete();
        dly_b.delete();
        for (int i = 0; i < SYNC; i++) begin
            dly_a.push_back(1'b0);
            dly_b.push_back(1'b0);
        end
        for (int s = 0; s < 2; s++) begin
            m_deb[s]  = 1'b0;
            m_run[s]  = 0;
            m_req[s]  = 1'b0;
            m_rose[s] = 1'b0;
        end
        cyc_n = 0;
    endtask

    task automatic modelStep(input bit ra, input bit rb, input bit ga, input bit gb);
        bit seen [2];
        bit stat [2];
        bit prev;
        seen[0] = dly_a.pop_front();
        dly_a.push_back(ra);
        seen[1] = dly_b.pop_front();
        dly_b.push_back(rb);
        stat[0] = ga;
        stat[1] = gb;
        cyc_n++;
        for (int s = 0; s < 2; s++) begin
            if (LATCH_ON) begin
                if (stat[s]) m_req[s] = 1'b0;
                else if (m_rose[s]) m_req[s] = 1'b1;
            end
            prev = m_deb[s];
            if (seen[s] != m_deb[s]) begin
                m_run[s]++;
                if (m_run[s] == DEB) begin
                    m_deb[s] = seen[s];
                    m_run[s] = 0;
                end
            end else begin
                m_run[s] = 0;
            end
            m_rose[s] = m_deb[s] && !prev;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare at negedge.
    task automatic applyStimulus(input bit ra, input bit rb, input bit ga, input bit gb);
        bus.SA_RAW  = ra;
        bus.SB_RAW  = rb;
        bus.GA_STAT = ga;
        bus.GB_STAT = gb;
        @(posedge CLK);
        if (RST) resetModel();
        else modelStep(ra, rb, ga, gb);
        @(negedge CLK);
        checkOutput("SA", bus.SA, m_deb[0] | m_req[0]);
        checkOutput("SB", bus.SB, m_deb[1] | m_req[1]);
        checkOutput("TICK", bus.TICK, (cyc_n > 0 && (cyc_n % DIV) == 0));
    endtask

    // Runs n cycles and reports the first cycle each output differs from its
    // starting value (-1 if it never changes).
    task automatic runMeasure(input bit ra, input bit rb, input bit ga, input bit gb, input int n,
                              output int chg_a, output int chg_b);
        logic sa0;
        logic sb0;
        sa0   = bus.SA;
        sb0   = bus.SB;
        chg_a = -1;
        chg_b = -1;
        for (int i = 1; i <= n; i++) begin
            applyStimulus(ra, rb, ga, gb);
            if (chg_a < 0 && bus.SA !== sa0) chg_a = i;
            if (chg_b < 0 && bus.SB !== sb0) chg_b = i;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  ca, cb, first_tick, ticks;
        bit  saw_high, found;
        bit  ra, rb, ga, gb;
        int  hold_a, hold_b;

        RST         = 1'b1;
        bus.SA_RAW  = 1'b0;
        bus.SB_RAW  = 1'b0;
        bus.GA_STAT = 1'b0;
        bus.GB_STAT = 1'b0;
        resetModel();
        #1;
        checkOutput("reset_SA", bus.SA, 1'b0);
        checkOutput("reset_SB", bus.SB, 1'b0);
        checkOutput("reset_TICK", bus.TICK, 1'b0);
        idle(2);
        RST = 1'b0;

        // First TICK exactly DIV cycles after release, then every DIV.
        first_tick = -1;
        ticks      = 0;
        for (int i = 1; i <= 3 * DIV; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (bus.TICK === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = i;
            end
        end
        checkOutput("first_tick", first_tick, DIV);
        checkOutput("tick_count", ticks, 3);

        // Clean edge on street A.
        runMeasure(1'b1, 1'b0, 1'b0, 1'b0, 20, ca, cb);
        checkOutput("clean_rise_lat", ca, LAT);
        checkOutput("clean_sb_quiet", cb, -1);
        runMeasure(1'b0, 1'b0, 1'b0, 1'b0, 20, ca, cb);
        checkOutput("clean_fall_lat", ca, LAT);
        checkOutput("clean_fall_sb_quiet", cb, -1);

        // Bounce on street B, then a stable high.
        saw_high = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, (i % 2) == 0, 1'b0, 1'b0);
            if (bus.SB !== 1'b0) saw_high = 1'b1;
        end
        checkOutput("bounce_quiet", saw_high, 1'b0);
        runMeasure(1'b0, 1'b1, 1'b0, 1'b0, 12, ca, cb);
        checkOutput("bounce_rise_lat", cb, LAT);
        idle(12);

        // Both streets arrive on the same cycle.
        runMeasure(1'b1, 1'b1, 1'b0, 1'b0, 12, ca, cb);
        checkOutput("simul_a_lat", ca, LAT);
        checkOutput("simul_b_lat", cb, LAT);

        // Reset mid-operation while SA, SB and TICK are all high.
        found = 1'b0;
        for (int i = 0; i < 2 * DIV && !found; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            if (bus.SA === 1'b1 && bus.SB === 1'b1 && bus.TICK === 1'b1) found = 1'b1;
        end
        checkOutput("all_active_found", found, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("async_rst_SA", bus.SA, 1'b0);
        checkOutput("async_rst_SB", bus.SB, 1'b0);
        checkOutput("async_rst_TICK", bus.TICK, 1'b0);
        resetModel();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        first_tick = -1;
        for (int i = 1; i <= 2 * DIV; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (first_tick < 0 && bus.TICK === 1'b1) first_tick = i;
        end
        checkOutput("post_rst_first_tick", first_tick, DIV);

`ifdef SENSOR_LATCH_EN
        // Latch holds demand after the car leaves, green clears it.
        idle(10);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);
        checkOutput("latch_hold_SA", bus.SA, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("latch_clear_SA", bus.SA, 1'b0);
        idle(4);

        // Green present on the cycle B's debounced level rises: no latch.
        found = 1'b0;
        for (int i = 0; i < 3 * LAT && !found; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            if (bus.SB === 1'b1) found = 1'b1;
        end
        checkOutput("collide_sb_rose", found, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        runMeasure(1'b0, 1'b0, 1'b0, 1'b0, 12, ca, cb);
        checkOutput("collide_sb_fall_lat", cb, LAT);
        checkOutput("collide_sb_final", bus.SB, 1'b0);
`endif

        // Randomized bursty sensors and occasional green status.
        ra = 1'b0;
        rb = 1'b0;
        hold_a = 0;
        hold_b = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold_a == 0) begin
                ra     = $urandom_range(0, 1);
                hold_a = $urandom_range(1, 8);
            end
            if (hold_b == 0) begin
                rb     = $urandom_range(0, 1);
                hold_b = $urandom_range(1, 8);
            end
            hold_a--;
            hold_b--;
            ga = ($urandom_range(0, 9) == 0);
            gb = ($urandom_range(0, 9) == 0);
            applyStimulus(ra, rb, ga, gb);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_cond.md
Name: traffic_sensor_cond

Overview:
Input-conditioning stage directly upstream of the two-street traffic-light controller. Takes raw, asynchronous vehicle-sensor contacts for street A and street B. Synchronizes and debounces them, and optionally latches each arrival until that street is served. Also produces a one-cycle TICK enable so the controller's state register advances at a human-scale rate. Drives the controller's SA/SB inputs and its state-advance enable.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (minimum 2)
DEB_CYCLES, 4, consecutive stable synchronized samples required before the debounced level changes (minimum 1)
DIV_RATIO, 8, CLK cycles per TICK pulse (minimum 2)
CNT_W, 8, width of the debounce and divider counters; must hold max(DEB_CYCLES, DIV_RATIO)-1

Ports:
CLK  input  1  system clock; all state updates on the rising edge
RST  input  1  asynchronous, active-high reset
SA_RAW  input  1  raw street-A sensor contact, asynchronous, may bounce
SB_RAW  input  1  raw street-B sensor contact, asynchronous, may bounce
GA_STAT  input  1  street-A green indication returned from the controller
GB_STAT  input  1  street-B green indication returned from the controller
SA  output  1  conditioned street-A demand to the controller
SB  output  1  conditioned street-B demand to the controller
TICK  output  1  single-cycle state-advance enable for the controller

Behaviour:
- Reset (asynchronous, RST=1): all synchronizer flops 0; debounced levels 0; debounce counters 0; request latches 0; divider counter 0. Outputs SA=0, SB=0, TICK=0. State holds while RST=1. First counting edge is the first rising CLK edge after RST falls.
- Synchronizer: each raw input passes through SYNC_STAGES flops. The synchronized value lags the raw value by SYNC_STAGES cycles.
- Debounce, per street:
  - The block holds a stable level DEB and a counter CNT.
  - If sync==DEB: CNT<=0.
  - Else if CNT==DEB_CYCLES-1: DEB<=sync and CNT<=0.
  - Else: CNT<=CNT+1.
  - A glitch shorter than DEB_CYCLES cycles never changes DEB.
  - Raw-to-DEB latency for a clean edge is SYNC_STAGES+DEB_CYCLES cycles: 6 with defaults.
- Request latch, per street (only when the optional feature is enabled):
  - REQ sets on the cycle DEB rises (0 to 1).
  - REQ clears on any cycle that street's green status (GA_STAT or GB_STAT) is 1.
  - If set and clear occur in the same cycle, clear wins: the arriving car is served by the current green.
  - SA = DEB_A | REQ_A; SB = DEB_B | REQ_B. All outputs are registered, with no combinational path from raw inputs.
- Divider:
  - DIV counts 0 to DIV_RATIO-1 and wraps to 0.
  - TICK=1 exactly in the cycle after DIV==DIV_RATIO-1, and is registered.
  - The first TICK comes DIV_RATIO cycles after reset release; the period is DIV_RATIO cycles, free-running.
  - TICK is independent of the sensor inputs.
- GA_STAT and GB_STAT are synchronous to CLK and need no synchronizer.
- Asserting RST mid-debounce or mid-latch discards all pending state immediately.

Optional Feature:
Macro: SENSOR_LATCH_EN.
- Defined: request latches exist as described above. A car that trips a sensor and leaves before its green still generates demand until that street's green is observed.
- Undefined: no latch flops are built. SA=DEB_A and SB=DEB_B. GA_STAT and GB_STAT are ignored (ports remain).

Decomposition:
- Shared package traffic_pkg holds:
  - default constants SYNC_STAGES_DEF, DEB_CYCLES_DEF, DIV_RATIO_DEF
  - the per-street index constants STREET_A=0 and STREET_B=1
- One natural sub-module, sensor_debounce: synchronizer plus debounce counter, parameterized by SYNC_STAGES, DEB_CYCLES and CNT_W, outputs DEB. It is instantiated twice.
- Latches and the divider stay in the top level.

Test Plan:
1. Reset check: RST=1 mid-operation while SA, SB and TICK are active -> all three drop to 0 asynchronously, before the next CLK edge. After release, the first TICK comes exactly 8 cycles later, then every 8 cycles.
2. Clean edge: SA_RAW 0 to 1 held for 20 cycles, latch disabled -> SA rises exactly 6 cycles after the raw edge. SA_RAW back to 0 -> SA falls 6 cycles later. SB stays 0 throughout.
3. Bounce: SB_RAW toggles 1,0,1,0 on alternating cycles for 10 cycles, then holds 1 -> SB never pulses during the bounce. SB rises 6 cycles after the final stable 1.
4. Latch (SENSOR_LATCH_EN): SA_RAW high for 8 cycles then low, GA_STAT=0 -> SA stays 1 after the debounced level falls. GA_STAT=1 for one cycle -> SA is 0 on the next cycle.
5. Set/clear collision (SENSOR_LATCH_EN): GB_STAT=1 in the same cycle the debounced B level rises -> REQ_B stays 0. SB follows the debounced level only and falls when SB_RAW is released.
6. Simultaneous streets: SA_RAW and SB_RAW rise on the same cycle -> SA and SB rise on the same cycle, 6 cycles later. TICK cadence is unaffected.
